// File: rtl/fma_seq_mac.sv
// Sequential signed a*b+c via sign-magnitude shift-add multiply; out_valid rises WIDTH+3 edges after accept.
// One operation in flight: in_ready only in IDLE, result held in DONE until out_ready consumes it.
module fma_seq_mac #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ABS, MUL, SIGN, ADD, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   ra, rb, rc;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      mag_a     <= '0;
      mag_b     <= '0;
      sign      <= 1'b0;
      prod      <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            rc    <= c;
            state <= ABS;
          end
        end
        ABS: begin
          // The most negative operand maps to 2^(WIDTH-1), still representable unsigned.
          mag_a <= ra[WIDTH-1] ? (~ra + ONE_W) : ra;
          mag_b <= rb[WIDTH-1] ? (~rb + ONE_W) : rb;
          sign  <= ra[WIDTH-1] ^ rb[WIDTH-1];
          prod  <= '0;
          count <= '0;
          state <= MUL;
        end
        MUL: begin
          if (mag_b[0])
            prod <= prod + ({{WIDTH{1'b0}}, mag_a} << count);
          mag_b <= mag_b >> 1;
          count <= count + ONE_C;
          if (count == LAST)
            state <= SIGN;
        end
        SIGN: begin
          if (sign)
            prod <= ~prod + ONE_P;
          state <= ADD;
        end
        ADD: begin
          out       <= prod + {{WIDTH{rc[WIDTH-1]}}, rc};
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE);

endmodule

// File: tb/tb_fma_seq_mac.sv
// Scoreboarded bench for fma_seq_mac: directed corner cases, backpressure, async reset, random back-to-back sweep.
module tb_fma_seq_mac;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   a = '0, b = '0, c = '0;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] out;

  fma_seq_mac #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] val;
    int             t;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     nres = 0;
  bit     spacing_on = 1'b0;
  int     last_accept = -1;
  int     busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain signed integer arithmetic, truncated to the result width.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    int r;
    r = int'($signed(x)) * int'($signed(y)) + int'($signed(z));
    return r[2*W-1:0];
  endfunction

  always @(posedge clk) cyc++;

  // Acceptance tracker: pushes expectations on each accepting edge.
  logic         pend = 1'b0;
  logic [W-1:0] pa, pb, pc;
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        sb.push_back('{model(pa, pb, pc), cyc});
        if (spacing_on && last_accept >= 0) begin
          chk("accept_spacing", cyc - last_accept, W + 5);
          chk("busy_cycles_per_op", busy_cnt, W + 4);
        end
        last_accept = cyc;
        busy_cnt = 0;
      end
      if (busy) busy_cnt++;
      pend = in_valid && in_ready;
      pa = a; pb = b; pc = c;
    end
  end

  // Monitor: compares each new result against the scoreboard head.
  logic prev_vld = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (out_valid && !prev_vld) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", out, 32'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          nres++;
          chk("result", out, e.val);
          chk("latency", cyc - e.t, W + 3);
        end
      end
      prev_vld = out_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents operands for exactly one accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic, input bit hold);
    int n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) chk("issue_timeout", 0, 1);
    a = ia; b = ib; c = ic;
    in_valid = 1'b1;
    step();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst = 1'b0;
    step();

    // Basic operation and handshake return to IDLE
    out_ready = 1'b1;
    issue(8'd3, 8'd5, 8'd1, 1'b0);
    wait_valid();
    step();
    chk("consumed_out_valid", out_valid, 0);
    chk("consumed_in_ready", in_ready, 1);
    chk("out_held_after_consume", out, 16'h0010);

    // Extreme magnitudes and sign corners
    issue(8'h80, 8'h80, 8'h7F, 1'b0);
    issue(8'h80, 8'h7F, 8'h80, 1'b0);
    issue(8'h00, 8'hF9, 8'hFF, 1'b0);
    issue(8'hFF, 8'h01, 8'h00, 1'b0);
    issue(8'hFF, 8'hFF, 8'hFF, 1'b0);
    wait_idle();

    // Backpressure: result held, extra in_valid ignored
    out_ready = 1'b0;
    issue(8'd12, 8'hFD, 8'd7, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out", out, 16'hFFE3);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      if (i == 2) begin a = 8'd1; b = 8'd1; c = 8'd1; in_valid = 1'b1; end
      if (i == 3) in_valid = 1'b0;
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    step();
    step();
    chk("bp_no_queued_op", busy, 0);

    // Asynchronous reset in the middle of the multiply
    issue(8'd7, 8'd9, 8'd5, 1'b0);
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    step();
    step();
    rst = 1'b0;
    step();
    issue(8'h9C, 8'h05, 8'h80, 1'b0);
    wait_idle();

    // Random back-to-back sweep with in_valid held high
    last_accept = -1;
    spacing_on = 1'b1;
    for (int i = 0; i < 1000; i++)
      issue(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    in_valid = 1'b0;
    wait_idle();
    step();
    step();

    chk("scoreboard_drained", sb.size(), 0);
    chk("result_count", nres, 1008);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
